addsub_serial: RTL and testbench
================================

Name: addsub_serial

Overview:
- Parametrised, multi-cycle successor to the team's combinational ripple adder.
- Processes one bit per clock, LSB first, for n cycles, so a single full-adder cell is reused.
- Adds subtract mode, signed saturation, a start/busy/done handshake, and carry/overflow/zero status flags.
- Sits between the calculator's operand registers and the display/result path; the controller issues one operation at a time.

Parameters:
- n, 6: operand and result width in bits; legal range n >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when busy = 0.
- op_sub  input  1  0 = a + b, 1 = a - b; sampled with start.
- sat_en  input  1  1 = signed saturation on overflow; sampled with start.
- a  input  n  operand A (two's complement or unsigned); sampled with start.
- b  input  n  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when result and flags update.
- result  output  n  final sum/difference; held until the next completion.
- carry  output  1  carry-out of the MSB; for subtract, 1 = no borrow (a >= b unsigned).
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  1 when the registered result (after saturation) is all zeros.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: state IDLE, busy 0, done 0, result 0, carry 0, overflow 0, zero 0, internal operand and shift registers 0, bit counter 0.
- States:
  - IDLE: waiting for start.
  - RUN: one bit processed per cycle.
  - DONE: one cycle; done = 1.
- IDLE -> RUN on start = 1 at edge k.
  - Latch a into the A shift register.
  - Latch b XOR {n{op_sub}} into the B shift register.
  - Serial carry := op_sub.
  - Counter := 0; latch sat_en; busy := 1.
- RUN, each edge:
  - sum bit = A[0] ^ B[0] ^ c; next c = majority(A[0], B[0], c).
  - Sum bit shifts into the MSB of the accumulating shift register; A and B shift right; counter increments.
  - When counter = n-2, the incoming carry is also captured as the MSB carry-in for overflow detection.
  - After the bit at counter = n-1 (edge k+n): go to DONE.
    - Write result, carry, overflow and zero; busy := 0; done := 1.
- DONE -> IDLE at the next edge; done := 0.
  - start asserted during the DONE cycle is accepted exactly as in IDLE, so back-to-back operations are possible.
- Latency:
  - start sampled at edge k -> done high during the cycle after edge k+n.
  - Throughput is one operation per n+1 cycles.
- start while busy = 1 (RUN) is ignored. No queueing, and no change to in-flight operands or mode.
- Arithmetic:
  - Modulo 2^n; carry and overflow are computed on the unsaturated sum.
  - Saturation applies only when the latched sat_en = 1 and overflow = 1:
    - a[n-1] = 0 -> result = 0 followed by n-1 ones (max positive).
    - a[n-1] = 1 -> result = 1 followed by n-1 zeros (min negative).
  - overflow still reads 1 when saturated; carry is not altered by saturation.
  - zero reflects the final (possibly saturated) result.
- Outputs result/carry/overflow/zero change only at completion edges and at reset; they are stable in all other cycles.
- Reset mid-operation aborts immediately:
  - No done pulse is generated.
  - Outputs return to their reset values.
  - The aborted operation is not resumed.
- Inputs a, b, op_sub and sat_en may change freely after the start edge without affecting the in-flight operation.

Test Plan:
- Reset then idle, n=6: all outputs at reset values; no done for 20 cycles with start = 0.
- Add and latency check, n=6: a=5, b=3, op_sub=0, start at edge k -> busy 1 for edges k+1..k+5; done pulse after edge k+6; result=8, carry=0, overflow=0, zero=0.
- Subtract with borrow: a=3, b=5, op_sub=1 -> result=62 (-2 signed), carry=0, overflow=0. Subtract equal: a=5, b=5 -> result=0, carry=1, zero=1.
- Signed overflow and saturation:
  - a=31, b=1, sat_en=0 -> result=32, overflow=1, carry=0.
  - Same with sat_en=1 -> result=31, overflow=1.
  - a=32, b=1, op_sub=1, sat_en=1 -> result=32 (min negative), overflow=1.
- Handshake edges:
  - start held high through RUN with changing a/b -> single done; result is from the operands latched at the first edge.
  - start in the DONE cycle -> second operation begins and its done arrives n+1 cycles after the first.
- Reset mid-operation: assert reset 3 cycles after start -> busy and outputs drop immediately to reset values; no done pulse; a new start afterwards completes normally (e.g. 10+20 -> result=30).

Source files
------------

// File: rtl/addsub_serial.sv
// Bit-serial add/subtract unit: one full-adder cell reused over n cycles, LSB first,
// with optional signed saturation and carry/overflow/zero status on completion.
module addsub_serial #(
  parameter int n = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         op_sub,
  input  logic         sat_en,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero
);

  localparam int CW = (n > 2) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [n-1:0]   a_sh;
  logic [n-1:0]   b_sh;
  logic [n-2:0]   acc;
  logic           c;
  logic           cin_msb;
  logic           sat_lat;
  logic           a_msb;
  logic [CW-1:0]  cnt;

  logic           accept;
  logic           last;
  logic           sum_bit;
  logic           c_next;
  logic [n-1:0]   raw;
  logic           ovf;
  logic [n-1:0]   sat_val;
  logic [n-1:0]   res_final;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Single full-adder cell; raw is the complete sum once the MSB bit is produced.
  always_comb begin
    last      = (state == RUN) && (cnt == CW'(n - 1));
    sum_bit   = a_sh[0] ^ b_sh[0] ^ c;
    c_next    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    raw       = {sum_bit, acc};
    ovf       = cin_msb ^ c_next;
    sat_val   = a_msb ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    res_final = (sat_lat && ovf) ? sat_val : raw;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      c        <= 1'b0;
      cin_msb  <= 1'b0;
      sat_lat  <= 1'b0;
      a_msb    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert B up front and seed the carry with 1.
      a_sh     <= a;
      b_sh     <= b ^ {n{op_sub}};
      acc      <= '0;
      c        <= op_sub;
      cin_msb  <= 1'b0;
      sat_lat  <= sat_en;
      a_msb    <= a[n-1];
      cnt      <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc  <= raw[n-1:1];
      c    <= c_next;
      cnt  <= cnt + 1'b1;
      if (cnt == CW'(n - 2)) cin_msb <= c_next;
      if (last) begin
        result   <= res_final;
        carry    <= c_next;
        overflow <= ovf;
        zero     <= (res_final == '0);
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_addsub_serial.sv
// Scoreboard bench for addsub_serial (n = 6): directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_addsub_serial;

  localparam int N = 6;

  typedef struct packed {
    logic [N-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic         op_sub;
  logic         sat_en;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         carry;
  logic         overflow;
  logic         zero;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   done_count = 0;
  int   last_done  = 0;
  int   prev_done  = 0;
  int   d0;

  addsub_serial #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op_sub(op_sub), .sat_en(sat_en),
    .a(a), .b(b), .busy(busy), .done(done), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_count++;
      prev_done = last_done;
      last_done = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_done: actual result %0d, expected no done", result);
      end else begin
        e = exp_q.pop_front();
        check_output("result", result, e.r);
        check_output("carry", carry, e.c);
        check_output("overflow", overflow, e.o);
        check_output("zero", zero, e.z);
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] r, input logic c, input logic o);
    exp_t e;
    e.r = r;
    e.c = c;
    e.o = o;
    e.z = (r == '0);
    exp_q.push_back(e);
  endtask

  // Issue one op from a negedge, scramble inputs after the start edge, check the busy/done timing.
  task automatic apply_stimulus(input logic [N-1:0] a_in, input logic [N-1:0] b_in,
                                input logic sub, input logic sat,
                                input logic [N-1:0] er, input logic ec, input logic eo);
    push_exp(er, ec, eo);
    a = a_in; b = b_in; op_sub = sub; sat_en = sat; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = N'($urandom);
    b = N'($urandom);
    op_sub = ~sub;
    sat_en = ~sat;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check_output("busy_run", busy, 1);
      check_output("done_run", done, 0);
      @(posedge clk);
    end
    @(negedge clk);
    check_output("done_pulse", done, 1);
    check_output("busy_done", busy, 0);
    @(posedge clk);
    @(negedge clk);
    check_output("done_one_cycle", done, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; op_sub = 1'b0; sat_en = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_result", result, 0);
    check_output("rst_carry", carry, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_zero", zero, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("idle_busy", busy, 0);
    end
    check_output("idle_no_done", done_count, 0);

    apply_stimulus(6'd5,  6'd3,  1'b0, 1'b0, 6'd8,  1'b0, 1'b0);
    apply_stimulus(6'd3,  6'd5,  1'b1, 1'b1, 6'd62, 1'b0, 1'b0);
    apply_stimulus(6'd5,  6'd5,  1'b1, 1'b0, 6'd0,  1'b1, 1'b0);
    apply_stimulus(6'd31, 6'd1,  1'b0, 1'b0, 6'd32, 1'b0, 1'b1);
    apply_stimulus(6'd31, 6'd1,  1'b0, 1'b1, 6'd31, 1'b0, 1'b1);
    apply_stimulus(6'd32, 6'd1,  1'b1, 1'b1, 6'd32, 1'b1, 1'b1);
    apply_stimulus(6'd63, 6'd1,  1'b0, 1'b1, 6'd0,  1'b1, 1'b0);
    apply_stimulus(6'd40, 6'd40, 1'b0, 1'b1, 6'd32, 1'b1, 1'b1);

    // start held high through RUN while operands change: only the first edge counts
    d0 = done_count;
    push_exp(6'd16, 1'b0, 1'b0);
    a = 6'd7; b = 6'd9; op_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      #1;
      a = N'($urandom_range(0, 63));
      b = N'($urandom_range(0, 63));
      op_sub = ~op_sub;
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("hold_single_done", done_count, d0 + 1);
    check_output("hold_idle", busy, 0);

    // back-to-back: second start issued during the DONE cycle
    push_exp(6'd17, 1'b0, 1'b0);
    a = 6'd12; b = 6'd5; op_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (N) @(posedge clk);
    #1;
    check_output("b2b_first_done", done, 1);
    push_exp(6'd13, 1'b1, 1'b0);
    a = 6'd20; b = 6'd7; op_sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_output("b2b_accepted", busy, 1);
    repeat (N) @(posedge clk);
    @(negedge clk);
    check_output("b2b_second_done", done, 1);
    @(posedge clk);
    @(negedge clk);
    check_output("b2b_spacing", last_done - prev_done, N + 1);

    // reset three cycles into an operation aborts it without a done pulse
    d0 = done_count;
    a = 6'd10; b = 6'd20; op_sub = 1'b0; sat_en = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_output("abort_busy", busy, 0);
    check_output("abort_done", done, 0);
    check_output("abort_result", result, 0);
    check_output("abort_carry", carry, 0);
    check_output("abort_overflow", overflow, 0);
    check_output("abort_zero", zero, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (N + 3) @(negedge clk);
    check_output("abort_no_done", done_count, d0);
    check_output("abort_idle", busy, 0);
    apply_stimulus(6'd10, 6'd20, 1'b0, 1'b0, 6'd30, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
